// File: rtl/bram_dp_be.sv
// True dual-port byte-enabled block RAM with read-before-write, port A priority on
// write-write collisions, and a collision counter. Optional parity storage: BRAM_PARITY_EN.
module bram_dp_be #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_BYTES = 4,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_a,
    input  logic [DATA_BYTES-1:0]   we_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [8*DATA_BYTES-1:0] wdata_a,
    output logic [8*DATA_BYTES-1:0] rdata_a,
    output logic                    rvalid_a,
    output logic [DATA_BYTES-1:0]   perr_a,
    input  logic                    req_b,
    input  logic [DATA_BYTES-1:0]   we_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [8*DATA_BYTES-1:0] wdata_b,
    output logic [8*DATA_BYTES-1:0] rdata_b,
    output logic                    rvalid_b,
    output logic [DATA_BYTES-1:0]   perr_b,
    output logic                    coll,
    output logic [15:0]             coll_cnt
);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef BRAM_PARITY_EN
    localparam int LW = 9;
`else
    localparam int LW = 8;
`endif
    typedef logic [DATA_BYTES-1:0][LW-1:0] word_t;

    generate
        if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
            $error("bram_dp_be: LATENCY must be 1 or 2");
        end
    endgenerate

    word_t                 wr_word_a, wr_word_b;
    word_t                 rd_word_a_p1, rd_word_b_p1;
    logic [DW-1:0]         data_a_p1, data_b_p1;
    logic [DATA_BYTES-1:0] perr_a_p1, perr_b_p1;
    logic [DATA_BYTES-1:0] lane_a, lane_b;
    logic                  vld_a_p1, vld_b_p1;
    logic                  same_addr, coll_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
        return (c == 16'hFFFF) ? c : c + {15'b0, inc};
    endfunction

`ifdef BRAM_PARITY_EN
    function automatic word_t encode(input logic [DW-1:0] d, input logic top);
        word_t w;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w[i] = {^d[8*i +: 8], d[8*i +: 8]};
`ifndef SYNTHESIS
            // Error-injection hook: 8'hA5 written into the top word stores a bad parity bit
            if (top && d[8*i +: 8] == 8'hA5) w[i][8] = ~w[i][8];
`endif
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] strip(input word_t w);
        logic [DW-1:0] d;
        for (int i = 0; i < DATA_BYTES; i++) d[8*i +: 8] = w[i][7:0];
        return d;
    endfunction

    function automatic logic [DATA_BYTES-1:0] par_err(input word_t w);
        logic [DATA_BYTES-1:0] e;
        for (int i = 0; i < DATA_BYTES; i++) e[i] = ^w[i];
        return e;
    endfunction

    assign wr_word_a = encode(wdata_a, addr_a == '1);
    assign wr_word_b = encode(wdata_b, addr_b == '1);
    assign data_a_p1 = strip(rd_word_a_p1);
    assign data_b_p1 = strip(rd_word_b_p1);
    assign perr_a_p1 = par_err(rd_word_a_p1);
    assign perr_b_p1 = par_err(rd_word_b_p1);
`else
    assign wr_word_a = wdata_a;
    assign wr_word_b = wdata_b;
    assign data_a_p1 = rd_word_a_p1;
    assign data_b_p1 = rd_word_b_p1;
    assign perr_a_p1 = '0;
    assign perr_b_p1 = '0;
`endif

    // Port A wins every lane it enables when both ports write the same word
    assign same_addr = (addr_a == addr_b);
    assign lane_a    = req_a ? we_a : '0;
    assign lane_b    = (req_b ? we_b : '0) & ~(same_addr ? lane_a : '0);
    assign coll_nxt  = req_b && same_addr && |(lane_a & we_b);

    // Stage p1: per-lane array write and read-before-write read register
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
        logic [LW-1:0] mem [DEPTH];
        logic [LW-1:0] rd_a_p1, rd_b_p1;

        always_ff @(posedge clk) begin
            if (lane_a[i]) mem[addr_a] <= wr_word_a[i];
            if (lane_b[i]) mem[addr_b] <= wr_word_b[i];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_a_p1 <= '0;
                rd_b_p1 <= '0;
            end else begin
                if (req_a) rd_a_p1 <= mem[addr_a];
                if (req_b) rd_b_p1 <= mem[addr_b];
            end
        end

        assign rd_word_a_p1[i] = rd_a_p1;
        assign rd_word_b_p1[i] = rd_b_p1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            vld_a_p1 <= req_a;
            vld_b_p1 <= req_b;
            coll     <= coll_nxt;
            coll_cnt <= sat_inc(coll_cnt, coll_nxt);
        end
    end

    // Stage p2: optional output register, loaded only when p1 holds valid data
    if (LATENCY == 2) begin : g_lat2
        logic [DW-1:0]         data_a_p2, data_b_p2;
        logic [DATA_BYTES-1:0] perr_a_p2, perr_b_p2;
        logic                  vld_a_p2, vld_b_p2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_a_p2 <= '0;
                data_b_p2 <= '0;
                perr_a_p2 <= '0;
                perr_b_p2 <= '0;
                vld_a_p2  <= 1'b0;
                vld_b_p2  <= 1'b0;
            end else begin
                vld_a_p2 <= vld_a_p1;
                vld_b_p2 <= vld_b_p1;
                if (vld_a_p1) begin
                    data_a_p2 <= data_a_p1;
                    perr_a_p2 <= perr_a_p1;
                end
                if (vld_b_p1) begin
                    data_b_p2 <= data_b_p1;
                    perr_b_p2 <= perr_b_p1;
                end
            end
        end

        assign rdata_a  = data_a_p2;
        assign rdata_b  = data_b_p2;
        assign perr_a   = perr_a_p2;
        assign perr_b   = perr_b_p2;
        assign rvalid_a = vld_a_p2;
        assign rvalid_b = vld_b_p2;
    end else begin : g_lat1
        assign rdata_a  = data_a_p1;
        assign rdata_b  = data_b_p1;
        assign perr_a   = perr_a_p1;
        assign perr_b   = perr_b_p1;
        assign rvalid_a = vld_a_p1;
        assign rvalid_b = vld_b_p1;
    end
endmodule

// File: tb/tb_bram_dp_be.sv
// Scoreboard bench for bram_dp_be: LATENCY=1 and LATENCY=2 instances share stimulus,
// expected read words come from a byte-level memory model with port A collision priority.
module tb_bram_dp_be;
`ifdef BRAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b;
    logic [3:0]  we_a, we_b;
    logic [11:0] addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic [31:0] rd_a1, rd_b1, rd_a2, rd_b2;
    logic        rv_a1, rv_b1, rv_a2, rv_b2;
    logic [3:0]  pe_a1, pe_b1, pe_a2, pe_b2;
    logic        coll1, coll2;
    logic [15:0] cnt1, cnt2;

    always #5 clk = ~clk;

    bram_dp_be #(.ADDR_WIDTH(12), .DATA_BYTES(4), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rd_a1), .rvalid_a(rv_a1), .perr_a(pe_a1),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rd_b1), .rvalid_b(rv_b1), .perr_b(pe_b1),
        .coll(coll1), .coll_cnt(cnt1));

    bram_dp_be #(.ADDR_WIDTH(12), .DATA_BYTES(4), .LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rd_a2), .rvalid_a(rv_a2), .perr_a(pe_a2),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rd_b2), .rvalid_b(rv_b2), .perr_b(pe_b2),
        .coll(coll2), .coll_cnt(cnt2));

    typedef struct {
        logic [31:0] data;
        logic [3:0]  perr;
        int          acc;
        bit          chk;
    } exp_t;

    // Queues: 0 = A/L1, 1 = B/L1, 2 = A/L2, 3 = B/L2
    exp_t        sb [4][$];
    logic [31:0] mdl  [int];
    logic [3:0]  pmdl [int];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic mon(input int k, input int lat, input string tag, input logic rv,
                       input logic [31:0] d, input logic [3:0] p);
        exp_t e;
        if (rv) begin
            if (sb[k].size() == 0) begin
                check({tag, "_spurious_rvalid"}, rv, 0);
            end else begin
                e = sb[k].pop_front();
                check({tag, "_latency"}, cyc - e.acc + 1, lat);
                if (e.chk) begin
                    check({tag, "_rdata"}, d, e.data);
                    check({tag, "_perr"}, p, e.perr);
                end
            end
        end else if (sb[k].size() > 0 && cyc - sb[k][0].acc + 1 >= lat) begin
            check({tag, "_missing_rvalid"}, rv, 1);
            void'(sb[k].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, 1, "a_l1", rv_a1, rd_a1, pe_a1);
            mon(1, 1, "b_l1", rv_b1, rd_b1, pe_b1);
            mon(2, 2, "a_l2", rv_a2, rd_a2, pe_a2);
            mon(3, 2, "b_l2", rv_b2, rd_b2, pe_b2);
        end
    end

    function automatic exp_t expect_rd(input int a, input bit chk);
        exp_t e;
        e.data = mdl.exists(a) ? mdl[a] : 32'h0;
        e.perr = pmdl.exists(a) ? pmdl[a] : 4'h0;
        e.acc  = cyc + 1;
        e.chk  = chk;
        return e;
    endfunction

    task automatic apply(input int a, input logic [3:0] we, input logic [31:0] d);
        logic [31:0] w;
        logic [3:0]  p;
        w = mdl.exists(a) ? mdl[a] : 32'h0;
        p = pmdl.exists(a) ? pmdl[a] : 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                w[8*i +: 8] = d[8*i +: 8];
                p[i] = PAR && (a == 12'hFFF) && (d[8*i +: 8] == 8'hA5);
            end
        end
        mdl[a]  = w;
        pmdl[a] = p;
    endtask

    task automatic access(input bit ra, input logic [3:0] wa, input logic [11:0] aa,
                          input logic [31:0] da, input bit rb, input logic [3:0] wb,
                          input logic [11:0] ab, input logic [31:0] db, input bit chk);
        exp_t ea, eb;
        @(negedge clk);
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        ea = expect_rd(int'(aa), chk);
        eb = expect_rd(int'(ab), chk);
        if (ra) begin sb[0].push_back(ea); sb[2].push_back(ea); end
        if (rb) begin sb[1].push_back(eb); sb[3].push_back(eb); end
        if (rb) apply(int'(ab), wb, db);
        if (ra) apply(int'(aa), wa, da);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_a = 1'b0; req_b = 1'b0; we_a = '0; we_b = '0;
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_l1_rdata"}, {rd_a1, rd_b1}, 0);
        check({tag, "_l1_ctl"}, {rv_a1, rv_b1, pe_a1, pe_b1, coll1, cnt1}, 0);
        check({tag, "_l2_rdata"}, {rd_a2, rd_b2}, 0);
        check({tag, "_l2_ctl"}, {rv_a2, rv_b2, pe_a2, pe_b2, coll2, cnt2}, 0);
    endtask

    task automatic chk_coll(input string tag, input logic c, input logic [15:0] n);
        check({tag, "_coll_l1"}, coll1, c);
        check({tag, "_cnt_l1"}, cnt1, n);
        check({tag, "_coll_l2"}, coll2, c);
        check({tag, "_cnt_l2"}, cnt2, n);
    endtask

    initial begin
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Known contents for every word touched below
        access(1, 4'hF, 12'h010, 32'h0, 1, 4'hF, 12'h020, 32'h11223344, 0);
        access(1, 4'hF, 12'h030, 32'h0, 1, 4'hF, 12'h040, 32'h0, 0);
        access(1, 4'hF, 12'hFFF, 32'h0, 0, 4'h0, 12'h000, 32'h0, 0);

        // Full write returns the prior word, then read back
        access(1, 4'hF, 12'h010, 32'hDEADBEEF, 0, 4'h0, 12'h000, 32'h0, 1);
        access(1, 4'h0, 12'h010, 32'h0, 0, 4'h0, 12'h000, 32'h0, 1);

        // Partial byte write on port B
        access(0, 4'h0, 12'h000, 32'h0, 1, 4'b0101, 12'h020, 32'hAABBCCDD, 1);
        access(0, 4'h0, 12'h000, 32'h0, 1, 4'h0, 12'h020, 32'h0, 1);

        // Both ports reading one address is not a collision
        access(1, 4'h0, 12'h010, 32'h0, 1, 4'h0, 12'h010, 32'h0, 1);
        idle(3);
        chk_coll("rr_same", 1'b0, 16'h0);

        // Write-write collision: lane 0 on both ports, lane 1 only on B
        access(1, 4'b0001, 12'h030, 32'h000000AA, 1, 4'b0011, 12'h030, 32'h0000BBCC, 1);
        idle(1);
        chk_coll("ww", 1'b1, 16'h1);
        idle(1);
        chk_coll("ww_after", 1'b0, 16'h1);
        access(1, 4'h0, 12'h030, 32'h0, 1, 4'h0, 12'h030, 32'h0, 1);

        // Cross-port read during write returns the old word
        access(1, 4'hF, 12'h040, 32'h5, 1, 4'h0, 12'h040, 32'h0, 1);
        access(0, 4'h0, 12'h000, 32'h0, 1, 4'h0, 12'h040, 32'h0, 1);

        // Parity injection at the top address
        access(1, 4'b0001, 12'hFFF, 32'h000000A5, 0, 4'h0, 12'h000, 32'h0, 1);
        access(1, 4'h0, 12'hFFF, 32'h0, 1, 4'h0, 12'hFFF, 32'h0, 1);
        access(1, 4'b0001, 12'hFFF, 32'h00000000, 0, 4'h0, 12'h000, 32'h0, 1);
        access(1, 4'h0, 12'hFFF, 32'h0, 0, 4'h0, 12'h000, 32'h0, 1);
        idle(3);

        // Counter saturation
        @(negedge clk);
        force u1.coll_cnt = 16'hFFFE;
        force u2.coll_cnt = 16'hFFFE;
        @(negedge clk);
        release u1.coll_cnt;
        release u2.coll_cnt;
        chk_coll("preset", 1'b0, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            access(1, 4'hF, 12'h030, 32'h100 + i, 1, 4'hF, 12'h030, 32'h200 + i, 1);
            idle(1);
            chk_coll("sat", 1'b1, 16'hFFFF);
        end
        idle(3);

        // Reset with a read still in flight in the two-stage instance
        access(1, 4'h0, 12'h010, 32'h0, 0, 4'h0, 12'h000, 32'h0, 1);
        idle(1);
        #2 rst_n = 1'b0;
        for (int k = 0; k < 4; k++) sb[k].delete();
        #1 chk_zero("in_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        chk_zero("post_rst");

        for (int k = 0; k < 4; k++) check("drain", sb[k].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bram_dp_be.md
Name: bram_dp_be

Overview:
- Parametrised single-clock true dual-port block RAM with per-byte write enables.
- Next generation of the fixed 32-bit/4096-word dual-port BRAM wrapper: width, depth and read latency are generic.
- Adds request/valid handshake, deterministic write-write collision resolution and a collision counter.
- Sits between CPU/video bus masters and on-chip memory; infers vendor BRAM, no primitive instantiation.

Parameters:
- ADDR_WIDTH, 12, word address bits; depth = 2**ADDR_WIDTH words.
- DATA_BYTES, 4, bytes per word; data width DW = 8*DATA_BYTES.
- LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register); any other value is a elaboration-time error.

Ports:
- clk  in  1  single clock for both ports.
- rst_n  in  1  asynchronous active-low reset.
- req_a  in  1  port A access request, one access per cycle.
- we_a  in  DATA_BYTES  port A byte write enables; all zero = read.
- addr_a  in  ADDR_WIDTH  port A word address.
- wdata_a  in  DW  port A write data; byte i = bits [8i+7:8i].
- rdata_a  out  DW  port A read data.
- rvalid_a  out  1  port A read data valid.
- perr_a  out  DATA_BYTES  port A per-byte parity error (see Optional Feature).
- req_b, we_b, addr_b, wdata_b, rdata_b, rvalid_b, perr_b: port B, same widths and meanings.
- coll  out  1  one-cycle pulse on a write-write same-address collision.
- coll_cnt  out  16  saturating count of collisions.

Behaviour:
- Reset (rst_n low, asynchronous): the following are cleared to 0:
  - rdata_a/b, rvalid_a/b, perr_a/b, coll, coll_cnt;
  - all pipeline stages.
- Memory array is not reset.
- Asserting reset mid-operation discards in-flight reads; no rvalid is issued for them after reset releases.
- Request acceptance:
  - Request accepted on a rising clk with req high; no back-pressure.
  - Each accepted request produces rvalid high for exactly one cycle, LATENCY cycles later.
  - Applies to reads and writes: a write returns the pre-write word (read-before-write).
- rdata timing:
  - rdata holds its last value while rvalid is low.
  - Back-to-back requests give back-to-back rvalid with no gaps.
- Write: only bytes with we bit set are updated; the other bytes keep their old contents.
- Same-cycle cross-port read/write to the same address: the reading port returns the old word; no bypass.
- Write-write collision (both ports write, addr_a == addr_b, same cycle):
  - Bytes enabled on both ports take port A data.
  - Bytes enabled only on B take port B data.
  - Bytes enabled only on A take port A data.
- Collision reporting:
  - coll is asserted in the following cycle only if at least one byte lane is enabled on both ports.
  - coll_cnt increments with coll and saturates at 16'hFFFF (no wrap).
- Both ports reading the same address: both get identical data; this is not a collision.
- Address range: full range 0 .. 2**ADDR_WIDTH-1; no wrap handling is needed since addresses are exact.
- Pipeline, LATENCY=2: stage 1 is the array read register, stage 2 the output register. The valid shift register tracks both stages.

Optional Feature:
- Macro: BRAM_PARITY_EN.
- Defined:
  - Each byte is stored as 9 bits: data plus an even-parity bit computed on write.
  - On read, parity is recomputed per byte.
  - perr bit i goes high, aligned with rvalid, when byte i mismatches.
  - Error injection for verification: a write with we[i] set and wdata byte equal to 8'hA5 while addr == all-ones stores inverted parity. This is simulation-only, guarded additionally by `ifndef SYNTHESIS.
- Undefined:
  - Storage is 8 bits per byte.
  - perr_a/b are tied to 0.
  - Ports remain present.

Test Plan:
- Reset, then port A writes 32'hDEADBEEF to 0x010 with we=4'hF; port A then reads 0x010. Required: the read returns rdata_a=32'hDEADBEEF with rvalid_a high exactly LATENCY cycles after the read request. The write's own rvalid returns the prior contents.
- Byte enables: with 0x020=32'h11223344, port B writes 32'hAABBCCDD with we=4'b0101, then reads 0x020. Required: rdata_b=32'h11BB33DD.
- Collision: A writes 32'h000000AA with we=4'b0001 and B writes 32'h0000BBCC with we=4'b0011, both to 0x030 in the same cycle. Required: coll pulses once, coll_cnt=1, and a later read of 0x030 returns low 16 bits 16'hBBAA.
- Read-during-write: 0x040 holds 32'h0, A writes 32'h5 while B reads 0x040 in the same cycle. Required: B returns 32'h0; a B read on the next cycle returns 32'h5.
- Reset mid-read (LATENCY=2): issue a read, drop rst_n one cycle later. Required: no rvalid after release, and all outputs are 0.
- Run saturation and parity at LATENCY 1 and 2:
  - Force coll_cnt to 16'hFFFE, then issue 3 collisions. Required: coll_cnt ends at 16'hFFFF.
  - With BRAM_PARITY_EN defined, inject a parity error at the top address. Required: perr=4'h1 on a read with we[0] set.
